// File: rtl/safe_pkg.sv
// ---------------------------------------------------------------------------
// safe_pkg
// Shared definitions for the safe lock controller: the FSM state enum, the
// LCD message codes, the BCD digit width, the timeout counter width and a
// small BCD increment helper.
// ---------------------------------------------------------------------------
package safe_pkg;

  // Controller states
  typedef enum logic [2:0] {
    LOCKED,
    ENTRY,
    CHECK,
    UNLOCKED,
    LOCKOUT
  } state_t;

  // LCD message codes
  localparam logic [2:0] MSG_LOCKED    = 3'd0;
  localparam logic [2:0] MSG_ENTER     = 3'd1;
  localparam logic [2:0] MSG_OPENED    = 3'd2;
  localparam logic [2:0] MSG_WRONG     = 3'd3;
  localparam logic [2:0] MSG_LOCKOUT   = 3'd4;
  localparam logic [2:0] MSG_DOOR_OPEN = 3'd5;

  // One BCD digit
  localparam int DIGIT_W = 4;

  // Width of every timeout down-counter
  localparam int TIMER_W = 16;

  // BCD increment that wraps 9 back to 0
  function automatic logic [DIGIT_W-1:0] bcdInc(input logic [DIGIT_W-1:0] v);
    return (v == 4'd9) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/safe_tick_gen.sv
// ---------------------------------------------------------------------------
// safe_tick_gen
// Prescaler (DIV clocks per tick) feeding a loadable down-counter. While
// load is high the prescaler restarts and the counter holds loadVal. Once
// load drops, the counter steps down once per tick. done pulses on the tick
// taken while the counter is already 0, so loading N-1 makes done fire on
// exactly the N-th tick after load is released.
//
// Ports:
//   clk     in   system clock
//   reset   in   synchronous active-high reset
//   load    in   hold the timer at its start value
//   loadVal in   start value (ticks - 1)
//   done    out  one-cycle pulse when the timeout expires
// ---------------------------------------------------------------------------
module safe_tick_gen
  import safe_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] loadVal,
  output logic               done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0]      pre;
  logic [TIMER_W-1:0] cnt;
  logic               tick;

  assign tick = (pre == PW'(DIV - 1));

  // Prescaler and down-counter. Load restarts both so a timeout always
  // measures whole ticks from the moment load was released.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre <= '0;
      cnt <= '0;
    end else if (load) begin
      pre <= '0;
      cnt <= loadVal;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign done = tick && (cnt == '0) && !load;

endmodule

// File: rtl/safe_lock_ctrl.sv
// ---------------------------------------------------------------------------
// safe_lock_ctrl
// Central sequencer of the safe: bolt drive, code entry, wrong-code counting
// with lockout and the single-entry LCD message channel.
//
// Optional feature macro: SAFE_AUTO_RELOCK_EN. When defined, the block
// relocks by itself once the door has stayed closed for RELOCK_TICKS ticks
// while unlocked.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   a, b               digit increment / digit confirm keys (levels)
//   open, lock         start entry / lock requests (levels)
//   doorCls            door closed sensor, 1 = closed
//   actuateLock        bolt drive, 1 = locked
//   openCls            1 while unlocked
//   digit_idx          index of the digit being entered
//   digit_val          current BCD digit value
//   msg_valid, msg_id  pending LCD message and its code
//   msg_ready          LCD driver accepts the pending message
// ---------------------------------------------------------------------------
module safe_lock_ctrl
  import safe_pkg::*;
#(
  parameter int                            div           = 1,
  parameter int                            CODE_LEN      = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0]   CODE          = 16'h1234,
  parameter int                            MAX_TRIES     = 3,
  parameter int                            LOCKOUT_TICKS = 1000,
  parameter int                            ENTRY_TICKS   = 500
`ifdef SAFE_AUTO_RELOCK_EN
  ,
  parameter int                            RELOCK_TICKS  = 200
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a,
  input  logic               b,
  input  logic               open,
  input  logic               lock,
  input  logic               doorCls,
  output logic               actuateLock,
  output logic               openCls,
  output logic [1:0]         digit_idx,
  output logic [DIGIT_W-1:0] digit_val,
  output logic               msg_valid,
  output logic [2:0]         msg_id,
  input  logic               msg_ready
);

  localparam int CW = CODE_LEN * DIGIT_W;
  localparam int FW = $clog2(MAX_TRIES + 1);

  state_t        state;
  logic [CW-1:0] entryCode;
  logic [FW-1:0] fail;

  logic aPrev, bPrev, openPrev, lockPrev;
  logic aRise, bRise, openRise, lockRise;
  logic entryLoad, entryDone;
  logic lockoutLoad, lockoutDone;
  logic relockDone;

  // One register per key so each level input produces a single-cycle
  // rising-edge strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      aPrev    <= 1'b0;
      bPrev    <= 1'b0;
      openPrev <= 1'b0;
      lockPrev <= 1'b0;
    end else begin
      aPrev    <= a;
      bPrev    <= b;
      openPrev <= open;
      lockPrev <= lock;
    end
  end

  assign aRise    = a    & ~aPrev;
  assign bRise    = b    & ~bPrev;
  assign openRise = open & ~openPrev;
  assign lockRise = lock & ~lockPrev;

  // Each timer is held loaded while its state is inactive, so it starts
  // fresh on every state entry. The entry timer also restarts on any key
  // activity that counts as progress.
  assign entryLoad   = (state != ENTRY) | aRise | bRise | openRise;
  assign lockoutLoad = (state != LOCKOUT);

  safe_tick_gen #(.DIV(div)) entryTimer (
    .clk    (clk),
    .reset  (reset),
    .load   (entryLoad),
    .loadVal(TIMER_W'(ENTRY_TICKS - 1)),
    .done   (entryDone)
  );

  safe_tick_gen #(.DIV(div)) lockoutTimer (
    .clk    (clk),
    .reset  (reset),
    .load   (lockoutLoad),
    .loadVal(TIMER_W'(LOCKOUT_TICKS - 1)),
    .done   (lockoutDone)
  );

`ifdef SAFE_AUTO_RELOCK_EN
  logic relockLoad;

  // An open door keeps the relock timer restarting, so it only expires
  // after the door has been closed for the full period.
  assign relockLoad = (state != UNLOCKED) | ~doorCls;

  safe_tick_gen #(.DIV(div)) relockTimer (
    .clk    (clk),
    .reset  (reset),
    .load   (relockLoad),
    .loadVal(TIMER_W'(RELOCK_TICKS - 1)),
    .done   (relockDone)
  );
`else
  assign relockDone = 1'b0;
`endif

  // Main sequencer with registered outputs. The message channel is cleared
  // first on msg_ready and any post further down overrides that, so a post
  // in the accept cycle leaves the new message pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOCKED;
      actuateLock <= 1'b1;
      openCls     <= 1'b0;
      digit_idx   <= '0;
      digit_val   <= '0;
      entryCode   <= '0;
      fail        <= '0;
      msg_valid   <= 1'b1;
      msg_id      <= MSG_LOCKED;
    end else begin
      if (msg_ready) begin
        msg_valid <= 1'b0;
      end
      case (state)
        LOCKED: begin
          if (openRise) begin
            state     <= ENTRY;
            digit_idx <= '0;
            digit_val <= '0;
            entryCode <= '0;
            msg_valid <= 1'b1;
            msg_id    <= MSG_ENTER;
          end
        end
        ENTRY: begin
          if (openRise) begin
            digit_idx <= '0;
            digit_val <= '0;
            entryCode <= '0;
          end else if (bRise) begin
            // b has priority over a simultaneous a edge
            entryCode <= {entryCode[CW-DIGIT_W-1:0], digit_val};
            digit_idx <= digit_idx + 1'b1;
            digit_val <= '0;
            if (digit_idx == 2'(CODE_LEN - 1)) begin
              state <= CHECK;
            end
          end else if (aRise) begin
            digit_val <= bcdInc(digit_val);
          end else if (entryDone) begin
            state     <= LOCKED;
            msg_valid <= 1'b1;
            msg_id    <= MSG_LOCKED;
          end
        end
        CHECK: begin
          msg_valid <= 1'b1;
          if (entryCode == CODE) begin
            state       <= UNLOCKED;
            actuateLock <= 1'b0;
            openCls     <= 1'b1;
            fail        <= '0;
            msg_id      <= MSG_OPENED;
          end else if (fail == FW'(MAX_TRIES - 1)) begin
            state  <= LOCKOUT;
            fail   <= fail + 1'b1;
            msg_id <= MSG_LOCKOUT;
          end else begin
            state  <= LOCKED;
            fail   <= fail + 1'b1;
            msg_id <= MSG_WRONG;
          end
        end
        LOCKOUT: begin
          if (lockoutDone) begin
            state     <= LOCKED;
            fail      <= '0;
            msg_valid <= 1'b1;
            msg_id    <= MSG_LOCKED;
          end
        end
        UNLOCKED: begin
          if (lockRise || relockDone) begin
            msg_valid <= 1'b1;
            if (doorCls) begin
              state       <= LOCKED;
              actuateLock <= 1'b1;
              openCls     <= 1'b0;
              msg_id      <= MSG_LOCKED;
            end else begin
              msg_id <= MSG_DOOR_OPEN;
            end
          end
        end
        default: begin
          state <= LOCKED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_safe_lock_ctrl
// Directed bench for safe_lock_ctrl with a behavioural reference model. The
// model tracks the safe as a mode, a queue of entered digits and an idle
// tick count, and its outputs are compared to the DUT on every falling edge.
// ---------------------------------------------------------------------------
module tb_safe_lock_ctrl;

  localparam int CODE_LEN      = 4;
  localparam int CODE          = 'h1234;
  localparam int MAX_TRIES     = 3;
  localparam int LOCKOUT_TICKS = 1000;
  localparam int ENTRY_TICKS   = 500;
  localparam int RELOCK_TICKS  = 200;

  localparam int M_LOCKED   = 0;
  localparam int M_ENTRY    = 1;
  localparam int M_CHECK    = 2;
  localparam int M_UNLOCKED = 3;
  localparam int M_LOCKOUT  = 4;

  logic       clk = 1'b0;
  logic       reset, a, b, open, lock, doorCls, msg_ready;
  logic       actuateLock, openCls, msg_valid;
  logic [1:0] digit_idx;
  logic [3:0] digit_val;
  logic [2:0] msg_id;

  int  nVec = 0;
  int  nErr = 0;
  bit  checkEn = 1'b0;

  // Reference model state
  int  mMode = M_LOCKED;
  int  mDigits[$];
  int  mVal = 0, mFail = 0, mIdle = 0, mMsg = 0;
  bit  mBolt = 1'b1, mOpenCls = 1'b0, mValid = 1'b1;
  bit  pa, pb, po, pl;
  int  codeDigits[CODE_LEN];

  always #5 clk = ~clk;

  safe_lock_ctrl #(
    .div          (1),
    .CODE_LEN     (CODE_LEN),
    .CODE         (16'h1234),
    .MAX_TRIES    (MAX_TRIES),
    .LOCKOUT_TICKS(LOCKOUT_TICKS),
    .ENTRY_TICKS  (ENTRY_TICKS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .open       (open),
    .lock       (lock),
    .doorCls    (doorCls),
    .actuateLock(actuateLock),
    .openCls    (openCls),
    .digit_idx  (digit_idx),
    .digit_val  (digit_val),
    .msg_valid  (msg_valid),
    .msg_id     (msg_id),
    .msg_ready  (msg_ready)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nVec++;
    if (actual !== expected) begin
      nErr++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // One clock of the safe's rules, applied to the sampled inputs
  task automatic modelStep();
    bit ea, eb, eo, el, post, match;
    int pid;
    if (reset) begin
      mMode = M_LOCKED; mDigits.delete(); mVal = 0; mFail = 0; mIdle = 0;
      mBolt = 1'b1; mOpenCls = 1'b0; mValid = 1'b1; mMsg = 0;
      pa = 0; pb = 0; po = 0; pl = 0;
      return;
    end
    ea = a && !pa; eb = b && !pb; eo = open && !po; el = lock && !pl;
    post = 1'b0; pid = 0;
    case (mMode)
      M_LOCKED: if (eo) begin
        mMode = M_ENTRY; mDigits.delete(); mVal = 0; mIdle = 0;
        post = 1'b1; pid = 1;
      end
      M_ENTRY: begin
        if (eo) begin
          mDigits.delete(); mVal = 0; mIdle = 0;
        end else if (eb) begin
          mDigits.push_back(mVal); mVal = 0; mIdle = 0;
          if (mDigits.size() == CODE_LEN) mMode = M_CHECK;
        end else if (ea) begin
          mVal = (mVal + 1) % 10; mIdle = 0;
        end else begin
          mIdle++;
          if (mIdle == ENTRY_TICKS) begin
            mMode = M_LOCKED; post = 1'b1; pid = 0;
          end
        end
      end
      M_CHECK: begin
        match = 1'b1;
        for (int i = 0; i < CODE_LEN; i++)
          if (mDigits[i] != codeDigits[i]) match = 1'b0;
        post = 1'b1; mIdle = 0;
        if (match) begin
          mMode = M_UNLOCKED; mBolt = 1'b0; mOpenCls = 1'b1; mFail = 0; pid = 2;
        end else begin
          mFail++;
          if (mFail >= MAX_TRIES) begin
            mMode = M_LOCKOUT; pid = 4;
          end else begin
            mMode = M_LOCKED; pid = 3;
          end
        end
      end
      M_LOCKOUT: begin
        mIdle++;
        if (mIdle == LOCKOUT_TICKS) begin
          mMode = M_LOCKED; mFail = 0; post = 1'b1; pid = 0;
        end
      end
      M_UNLOCKED: begin
        bit relock;
        relock = 1'b0;
`ifdef SAFE_AUTO_RELOCK_EN
        if (!doorCls) mIdle = 0;
        else begin
          mIdle++;
          if (mIdle == RELOCK_TICKS) relock = 1'b1;
        end
`endif
        if (el || relock) begin
          post = 1'b1;
          if (doorCls) begin
            mMode = M_LOCKED; mBolt = 1'b1; mOpenCls = 1'b0; pid = 0;
          end else begin
            pid = 5;
          end
        end
      end
      default: ;
    endcase
    if (msg_ready) mValid = 1'b0;
    if (post) begin
      mValid = 1'b1; mMsg = pid;
    end
    pa = a; pb = b; po = open; pl = lock;
  endtask

  // Model advances on every rising edge
  initial begin
    for (int i = 0; i < CODE_LEN; i++)
      codeDigits[i] = (CODE >> (4 * (CODE_LEN - 1 - i))) & 15;
    forever begin
      @(posedge clk);
      modelStep();
    end
  end

  // Cycle-by-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (checkEn) begin
        checkOutput("actuateLock", actuateLock, mBolt);
        checkOutput("openCls", openCls, mOpenCls);
        checkOutput("digit_idx", digit_idx, mDigits.size() % 4);
        checkOutput("digit_val", digit_val, mVal);
        checkOutput("msg_valid", msg_valid, mValid);
        if (mValid) checkOutput("msg_id", msg_id, mMsg);
      end
    end
  end

  task automatic applyStimulus(input logic na, input logic nb, input logic nopen,
                               input logic nlock, input int cycles);
    a = na; b = nb; open = nopen; lock = nlock;
    repeat (cycles) @(negedge clk);
  endtask

  // key: 0 a, 1 b, 2 open, 3 lock
  task automatic pressKey(input int key);
    applyStimulus(key == 0, key == 1, key == 2, key == 3, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
  endtask

  task automatic enterDigit(input int d);
    repeat (d) pressKey(0);
    pressKey(1);
  endtask

  task automatic enterCode(input int d0, input int d1, input int d2, input int d3);
    pressKey(2);
    enterDigit(d0); enterDigit(d1); enterDigit(d2); enterDigit(d3);
  endtask

  initial begin
    reset = 1'b1; a = 0; b = 0; open = 0; lock = 0; doorCls = 1'b1; msg_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkEn = 1'b1;

    // Reset state and message acknowledge
    checkOutput("rst_actuateLock", actuateLock, 1);
    checkOutput("rst_openCls", openCls, 0);
    checkOutput("rst_msg_valid", msg_valid, 1);
    checkOutput("rst_msg_id", msg_id, 0);
    reset = 1'b0;
    @(negedge clk);
    msg_ready = 1'b1;
    @(negedge clk);
    msg_ready = 1'b0;
    checkOutput("ack_msg_valid", msg_valid, 0);

    // Correct code opens the safe
    enterCode(1, 2, 3, 4);
    checkOutput("open_openCls", openCls, 1);
    checkOutput("open_actuateLock", actuateLock, 0);
    checkOutput("open_msg_id", msg_id, 2);

    // Lock with door open is refused, with door closed it locks
    doorCls = 1'b0;
    pressKey(3);
    checkOutput("dooropen_msg_id", msg_id, 5);
    checkOutput("dooropen_actuateLock", actuateLock, 0);
    doorCls = 1'b1;
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("lock_actuateLock", actuateLock, 1);
    checkOutput("lock_msg_id", msg_id, 0);
    applyStimulus(0, 0, 0, 0, 1);

    // Three wrong codes lead to lockout
    enterCode(1, 2, 3, 5);
    checkOutput("wrong1_msg_id", msg_id, 3);
    enterCode(1, 2, 3, 5);
    checkOutput("wrong2_msg_id", msg_id, 3);
    enterCode(1, 2, 3, 5);
    checkOutput("wrong3_msg_id", msg_id, 4);
    pressKey(0); pressKey(0); pressKey(2); pressKey(0);
    checkOutput("lockout_digit_val", digit_val, 0);
    checkOutput("lockout_msg_id", msg_id, 4);
    applyStimulus(0, 0, 0, 0, LOCKOUT_TICKS);
    checkOutput("afterlockout_msg_id", msg_id, 0);
    enterCode(1, 2, 3, 5);
    checkOutput("failcleared_msg_id", msg_id, 3);

    // Digit wrap, a+b collision and entry timeout
    pressKey(2);
    repeat (9) pressKey(0);
    checkOutput("nine_digit_val", digit_val, 9);
    pressKey(0);
    checkOutput("wrap_digit_val", digit_val, 0);
    repeat (3) pressKey(0);
    applyStimulus(1, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("ab_digit_idx", digit_idx, 1);
    checkOutput("ab_digit_val", digit_val, 0);
    applyStimulus(0, 0, 0, 0, ENTRY_TICKS - 2);
    checkOutput("pretimeout_msg_id", msg_id, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("timeout_msg_id", msg_id, 0);
    checkOutput("timeout_actuateLock", actuateLock, 1);

    // Unlock with a message accepted in the posting cycle, then relock test
    msg_ready = 1'b1;
    pressKey(2);
    msg_ready = 1'b0;
    enterDigit(1); enterDigit(2); enterDigit(3); enterDigit(4);
    checkOutput("reopen_openCls", openCls, 1);
    doorCls = 1'b0;
    applyStimulus(0, 0, 0, 0, 5);
    doorCls = 1'b1;
    applyStimulus(0, 0, 0, 0, RELOCK_TICKS - 1);
    checkOutput("prerelock_openCls", openCls, 1);
    applyStimulus(0, 0, 0, 0, 1);
`ifdef SAFE_AUTO_RELOCK_EN
    checkOutput("relock_actuateLock", actuateLock, 1);
    checkOutput("relock_msg_id", msg_id, 0);
`else
    applyStimulus(0, 0, 0, 0, 1000);
    checkOutput("norelock_openCls", openCls, 1);
    checkOutput("norelock_actuateLock", actuateLock, 0);
    pressKey(3);
    checkOutput("final_actuateLock", actuateLock, 1);
`endif
    applyStimulus(0, 0, 0, 0, 3);

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
